or1k_mpsoc_boot_ctrl: RTL and testbench

- Synthesizable boot sequencer for the OR1K MPSoC.
- Serves all N = X*Y*Z*CORES_PER_TILE cores, which are indexed linearly as ((x*Y+y)*Z+z)*CORES_PER_TILE+t.
- After system reset it optionally zero-fills each core's local memory through one shared Wishbone master, then releases the per-core resets in a staggered order.
- Afterwards it services per-core reboot requests: re-hold reset, optional re-clear, release.
- Sits between the top-level clock/reset pads and the tile memories and cores.

---
 rtl/or1k_boot_pkg.sv | 24 ++
 rtl/or1k_boot_wb_clr.sv | 62 ++++++
 rtl/or1k_mpsoc_boot_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_or1k_mpsoc_boot_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/or1k_boot_pkg.sv
// Shared types and constants for the OR1K MPSoC boot sequencer.
package or1k_boot_pkg;

  typedef enum logic [2:0] {
    HOLD,
    CLR,
    REL,
    RUN,
    RB_HOLD,
    RB_CLR
  } boot_state_t;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;

  // Linear core index of core t in tile (x,y,z) of an X*Y*Z mesh.
  function automatic int unsigned ch_index(input int unsigned x, input int unsigned y,
                                           input int unsigned z, input int unsigned t,
                                           input int unsigned ny, input int unsigned nz,
                                           input int unsigned cpt);
    return ((x * ny + y) * nz + z) * cpt + t;
  endfunction

endpackage

// File: rtl/or1k_boot_wb_clr.sv
// Zero-fill engine: writes 'words' zero words to one memory channel over a
// classic Wishbone master, then reports done (and fail on a bus error).
module or1k_boot_wb_clr
  import or1k_boot_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int CW = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [CW-1:0] ch,
  input  logic [31:0]   words,
  input  logic          ack,
  input  logic          err,
  output logic          cyc,
  output logic          stb,
  output logic          we,
  output logic [CW-1:0] ch_o,
  output logic [AW-1:0] adr,
  output logic          done,
  output logic          fail
);

  logic        active;
  logic [31:0] wcnt;
  logic        last;

  // A bus error ends the channel early; ack+err together counts as error.
  assign last = (wcnt == words - 32'd1);
  assign done = active & (err | (ack & last));
  assign fail = active & err;

  assign cyc  = active;
  assign stb  = active;
  assign we   = active;
  assign ch_o = ch;

  // Word sequencer: stb stays high across acks, drops after the final word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active <= 1'b0;
      wcnt   <= '0;
      adr    <= '0;
    end else if (!active) begin
      if (start) begin
        active <= 1'b1;
        wcnt   <= '0;
        adr    <= '0;
      end
    end else if (done) begin
      active <= 1'b0;
      wcnt   <= '0;
      adr    <= '0;
    end else if (ack) begin
      wcnt <= wcnt + 32'd1;
      adr  <= adr + AW'(DW / 8);
    end
  end

endmodule

// File: rtl/or1k_mpsoc_boot_ctrl.sv
// Boot sequencer: holds all core resets, optionally zero-fills every core's
// local memory, releases cores in a staggered order, then serves reboots.
module or1k_mpsoc_boot_ctrl
  import or1k_boot_pkg::*;
#(
  parameter int          X              = 2,
  parameter int          Y              = 2,
  parameter int          Z              = 2,
  parameter int          CORES_PER_TILE = 2,
  parameter logic [31:0] MEM_SIZE       = 32'h02000000,
  parameter int          AW             = 32,
  parameter int          DW             = 32,
  parameter int          RST_HOLD       = 16,
  parameter int          STAGGER        = 4,
  localparam int         N              = X * Y * Z * CORES_PER_TILE,
  localparam int         CW             = (N > 1) ? $clog2(N) : 1
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            clear_i,
  input  logic [N-1:0]    reboot_i,
  output logic [N-1:0]    core_rst_o,
  output logic [CW-1:0]   wbm_ch_o,
  output logic [AW-1:0]   wbm_adr_o,
  output logic [DW-1:0]   wbm_dat_o,
  output logic [DW/8-1:0] wbm_sel_o,
  output logic            wbm_we_o,
  output logic            wbm_cyc_o,
  output logic            wbm_stb_o,
  output logic [2:0]      wbm_cti_o,
  output logic [1:0]      wbm_bte_o,
  input  logic            wbm_ack_i,
  input  logic            wbm_err_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            err_o
);

  localparam logic [31:0]   WORDS     = MEM_SIZE / 32'(DW / 8);
  localparam logic [31:0]   HOLD_LAST = 32'(RST_HOLD - 1);
  localparam logic [31:0]   STG_LAST  = 32'(STAGGER - 1);
  localparam logic [CW-1:0] LAST_CH   = CW'(N - 1);

  boot_state_t   state, state_d;
  logic [31:0]   cnt, cnt_d;
  logic [CW-1:0] ch, ch_d;
  logic [CW-1:0] rel_idx, rel_d;
  logic [N-1:0]  core_rst, core_rst_d;
  logic [N-1:0]  pending, pend_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          hold_start, rel_enter;
  logic [CW-1:0] pick;
  logic          eng_start, eng_cyc, eng_done, eng_fail;

  function automatic logic [CW-1:0] lowest_set(input logic [N-1:0] v);
    lowest_set = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = CW'(i);
    end
  endfunction

  // Start the engine on hold exit, and again in the idle gap between channels.
  assign eng_start = hold_start | (((state == CLR) | (state == RB_CLR)) & ~eng_cyc);

  or1k_boot_wb_clr #(.AW(AW), .DW(DW), .CW(CW)) u_clr (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .start (eng_start),
    .ch    (ch),
    .words (WORDS),
    .ack   (wbm_ack_i),
    .err   (wbm_err_i),
    .cyc   (eng_cyc),
    .stb   (wbm_stb_o),
    .we    (wbm_we_o),
    .ch_o  (wbm_ch_o),
    .adr   (wbm_adr_o),
    .done  (eng_done),
    .fail  (eng_fail)
  );

  assign wbm_cyc_o  = eng_cyc;
  assign wbm_dat_o  = '0;
  assign wbm_sel_o  = '1;
  assign wbm_cti_o  = CTI_CLASSIC;
  assign wbm_bte_o  = BTE_LINEAR;
  assign core_rst_o = core_rst;
  assign busy_o     = (state != RUN);
  assign done_o     = done_q;
  assign err_o      = err_q;

  // State and sequencer registers.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state    <= HOLD;
      cnt      <= '0;
      ch       <= '0;
      rel_idx  <= '0;
      core_rst <= '1;
      pending  <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      ch       <= ch_d;
      rel_idx  <= rel_d;
      core_rst <= core_rst_d;
      pending  <= pend_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // Next-state: hold, clear, staggered release, then reboot servicing.
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    ch_d       = ch;
    rel_d      = rel_idx;
    core_rst_d = core_rst;
    pend_d     = pending | (reboot_i & ~core_rst);
    done_d     = done_q;
    err_d      = err_q;
    hold_start = 1'b0;
    rel_enter  = 1'b0;
    pick       = lowest_set(pending);
    case (state)
      HOLD, RB_HOLD: begin
        if (cnt == HOLD_LAST) begin
          cnt_d = '0;
          if (clear_i) begin
            hold_start = 1'b1;
            if (state == HOLD) begin
              state_d = CLR;
              ch_d    = '0;
            end else begin
              state_d = RB_CLR;
            end
          end else if (state == HOLD) begin
            rel_enter = 1'b1;
          end else begin
            core_rst_d[ch] = 1'b0;
            state_d        = RUN;
          end
        end else begin
          cnt_d = cnt + 32'd1;
        end
      end
      CLR: begin
        if (eng_done) begin
          if (eng_fail) err_d = 1'b1;
          if (ch == LAST_CH) rel_enter = 1'b1;
          else ch_d = ch + CW'(1);
        end
      end
      REL: begin
        if (cnt == STG_LAST) begin
          cnt_d               = '0;
          core_rst_d[rel_idx] = 1'b0;
          if (rel_idx == LAST_CH) begin
            done_d  = 1'b1;
            state_d = RUN;
          end else begin
            rel_d = rel_idx + CW'(1);
          end
        end else begin
          cnt_d = cnt + 32'd1;
        end
      end
      RUN: begin
        if (|pending) begin
          pend_d[pick]     = 1'b0;
          core_rst_d[pick] = 1'b1;
          ch_d             = pick;
          cnt_d            = '0;
          state_d          = RB_HOLD;
        end
      end
      RB_CLR: begin
        if (eng_done) begin
          if (eng_fail) err_d = 1'b1;
          core_rst_d[ch] = 1'b0;
          state_d        = RUN;
        end
      end
      default: state_d = HOLD;
    endcase
    // Core 0 leaves reset in the first release cycle.
    if (rel_enter) begin
      core_rst_d[0] = 1'b0;
      cnt_d         = '0;
      rel_d         = CW'(1);
      if (N == 1) begin
        done_d  = 1'b1;
        state_d = RUN;
      end else begin
        state_d = REL;
      end
    end
  end

endmodule

// File: tb/tb_or1k_mpsoc_boot_ctrl.sv
// Bench for the boot sequencer: a trace model predicts every sampled cycle.
module tb_or1k_mpsoc_boot_ctrl;
  import or1k_boot_pkg::*;

  localparam int N        = 2;
  localparam int CW       = 1;
  localparam int WORDS    = 4;
  localparam int RST_HOLD = 4;
  localparam int STAGGER  = 2;
  localparam int MAXL     = 64;

  logic          clk = 1'b0;
  logic          wb_rst_i = 1'b0;
  logic          clear_i = 1'b0;
  logic [N-1:0]  reboot_i = '0;
  logic [N-1:0]  core_rst_o;
  logic [CW-1:0] wbm_ch_o;
  logic [31:0]   wbm_adr_o;
  logic [31:0]   wbm_dat_o;
  logic [3:0]    wbm_sel_o;
  logic          wbm_we_o, wbm_cyc_o, wbm_stb_o;
  logic [2:0]    wbm_cti_o;
  logic [1:0]    wbm_bte_o;
  logic          wbm_ack_i, wbm_err_i;
  logic          busy_o, done_o, err_o;

  // slave fault injection
  logic          sc_err_en = 1'b0;
  logic [CW-1:0] sc_err_ch = '0;
  logic [31:0]   sc_err_adr = '0;
  logic          err_now;

  int    checks = 0;
  int    errors = 0;
  string tname = "init";
  bit    cmp_en = 1'b0;
  int    cur = 1;

  // model trace
  logic [N-1:0] reb    [1:MAXL];
  logic [N-1:0] e_rst  [1:MAXL];
  bit           e_cyc  [1:MAXL];
  int           e_ch   [1:MAXL];
  int           e_adr  [1:MAXL];
  bit           e_done [1:MAXL];
  bit           e_busy [1:MAXL];
  bit           e_err  [1:MAXL];
  int           ms;
  logic [N-1:0] m_held, m_pend;
  bit           m_done, m_busy, m_err;
  bit           sc_clear;
  bit           sc_inj;
  int           sc_inj_ch, sc_inj_w;

  always #5 clk = ~clk;

  assign err_now   = sc_err_en && (wbm_ch_o == sc_err_ch) && (wbm_adr_o == sc_err_adr);
  assign wbm_ack_i = wbm_cyc_o & wbm_stb_o & ~err_now;
  assign wbm_err_i = wbm_cyc_o & wbm_stb_o & err_now;

  or1k_mpsoc_boot_ctrl #(
    .X(1), .Y(1), .Z(1), .CORES_PER_TILE(2), .MEM_SIZE(32'd16),
    .AW(32), .DW(32), .RST_HOLD(RST_HOLD), .STAGGER(STAGGER)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(wb_rst_i), .clear_i(clear_i), .reboot_i(reboot_i),
    .core_rst_o(core_rst_o), .wbm_ch_o(wbm_ch_o), .wbm_adr_o(wbm_adr_o),
    .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o), .wbm_we_o(wbm_we_o),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_cti_o(wbm_cti_o),
    .wbm_bte_o(wbm_bte_o), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s: got 0x%0h expected 0x%0h", tname, nm, act, exp);
    end
  endtask

  // One sampled cycle of the expected trace; reboot requests of free cores latch.
  task automatic emit(input bit cyc, input int ch, input int adr);
    if (ms <= MAXL) begin
      e_rst[ms]  = m_held;
      e_cyc[ms]  = cyc;
      e_ch[ms]   = ch;
      e_adr[ms]  = adr;
      e_done[ms] = m_done;
      e_busy[ms] = m_busy;
      e_err[ms]  = m_err;
      m_pend     = m_pend | (reb[ms] & ~m_held);
    end
    ms++;
  endtask

  task automatic build_model();
    logic [N-1:0] p;
    int c;
    ms = 1; m_held = '1; m_pend = '0; m_done = 0; m_busy = 1; m_err = 0;
    repeat (RST_HOLD) emit(0, 0, 0);
    if (sc_clear) begin
      for (int ch = 0; ch < N; ch++) begin
        if (ch > 0) emit(0, 0, 0);
        for (int w = 0; w < WORDS; w++) begin
          emit(1, ch, 4 * w);
          if (sc_inj && ch == sc_inj_ch && w == sc_inj_w) begin
            m_err = 1;
            break;
          end
        end
      end
    end
    m_held[0] = 1'b0;
    for (int k = 1; k < N; k++) begin
      repeat (STAGGER) emit(0, 0, 0);
      m_held[k] = 1'b0;
    end
    m_done = 1; m_busy = 0;
    while (ms <= MAXL) begin
      p = m_pend;
      emit(0, 0, 0);
      if (p != '0) begin
        c = 0;
        for (int i = N - 1; i >= 0; i--) if (p[i]) c = i;
        m_pend[c] = 1'b0;
        m_held[c] = 1'b1;
        m_busy = 1;
        repeat (RST_HOLD) emit(0, 0, 0);
        if (sc_clear) for (int w = 0; w < WORDS; w++) emit(1, c, 4 * w);
        m_held[c] = 1'b0;
        m_busy = 0;
      end
    end
  endtask

  // Compare process: every sampled cycle against the model trace.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk($sformatf("s%0d core_rst", cur), 32'(core_rst_o), 32'(e_rst[cur]));
      chk($sformatf("s%0d cyc", cur), 32'(wbm_cyc_o), 32'(e_cyc[cur]));
      chk($sformatf("s%0d stb", cur), 32'(wbm_stb_o), 32'(e_cyc[cur]));
      chk($sformatf("s%0d we", cur), 32'(wbm_we_o), 32'(e_cyc[cur]));
      if (e_cyc[cur]) begin
        chk($sformatf("s%0d ch", cur), 32'(wbm_ch_o), 32'(e_ch[cur]));
        chk($sformatf("s%0d adr", cur), wbm_adr_o, 32'(e_adr[cur]));
        chk($sformatf("s%0d dat", cur), wbm_dat_o, 32'd0);
        chk($sformatf("s%0d sel", cur), 32'(wbm_sel_o), 32'hF);
        chk($sformatf("s%0d cti", cur), 32'(wbm_cti_o), 32'd0);
        chk($sformatf("s%0d bte", cur), 32'(wbm_bte_o), 32'd0);
      end
      chk($sformatf("s%0d done", cur), 32'(done_o), 32'(e_done[cur]));
      chk($sformatf("s%0d busy", cur), 32'(busy_o), 32'(e_busy[cur]));
      chk($sformatf("s%0d err", cur), 32'(err_o), 32'(e_err[cur]));
    end
  end

  task automatic do_reset();
    wb_rst_i = 1'b1;
    #2;
    chk("rst core_rst", 32'(core_rst_o), 32'h3);
    chk("rst cyc", 32'(wbm_cyc_o), 32'd0);
    chk("rst stb", 32'(wbm_stb_o), 32'd0);
    chk("rst we", 32'(wbm_we_o), 32'd0);
    chk("rst adr", wbm_adr_o, 32'd0);
    chk("rst ch", 32'(wbm_ch_o), 32'd0);
    chk("rst busy", 32'(busy_o), 32'd1);
    chk("rst done", 32'(done_o), 32'd0);
    chk("rst err", 32'(err_o), 32'd0);
    repeat (2) @(posedge clk);
    #1 wb_rst_i = 1'b0;
  endtask

  // Drives one sample per period starting right after reset release.
  task automatic run(input int L);
    build_model();
    cmp_en = 1'b1;
    for (int s = 1; s <= L; s++) begin
      cur = s;
      reboot_i = reb[s];
      @(negedge clk);
      if (s < L) begin
        @(posedge clk);
        #1;
      end
    end
    #1 cmp_en = 1'b0;
    reboot_i = '0;
  endtask

  task automatic setup(input string nm, input bit clr);
    tname = nm;
    sc_clear = clr;
    clear_i = clr;
    sc_inj = 0; sc_err_en = 1'b0;
    for (int i = 1; i <= MAXL; i++) reb[i] = '0;
  endtask

  initial begin
    #1;
    tname = "pkg";
    chk("ch_index", ch_index(1, 1, 1, 1, 2, 2, 2), 32'd15);
    do_reset();

    // 1: no clear, staggered release
    setup("t1", 0);
    run(10);
    chk("m rst@4", 32'(e_rst[4]), 32'h3);
    chk("m rst@5", 32'(e_rst[5]), 32'h2);
    chk("m rst@6", 32'(e_rst[6]), 32'h2);
    chk("m rst@7", 32'(e_rst[7]), 32'h0);
    chk("m done@6", 32'(e_done[6]), 32'd0);
    chk("m done@7", 32'(e_done[7]), 32'd1);
    do_reset();

    // 2: full clear of both channels
    setup("t2", 1);
    run(18);
    chk("m cyc@5", 32'(e_cyc[5]), 32'd1);
    chk("m adr@8", 32'(e_adr[8]), 32'd12);
    chk("m cyc@9", 32'(e_cyc[9]), 32'd0);
    chk("m ch@10", 32'(e_ch[10]), 32'd1);
    chk("m rst@14", 32'(e_rst[14]), 32'h2);
    chk("m done@16", 32'(e_done[16]), 32'd1);
    do_reset();

    // 3: bus error on ch0 word 1
    setup("t3", 1);
    sc_inj = 1; sc_inj_ch = 0; sc_inj_w = 1;
    sc_err_en = 1'b1; sc_err_ch = '0; sc_err_adr = 32'd4;
    run(16);
    chk("m err@6", 32'(e_err[6]), 32'd0);
    chk("m err@7", 32'(e_err[7]), 32'd1);
    chk("m cyc@7", 32'(e_cyc[7]), 32'd0);
    chk("m adr@11", 32'(e_adr[11]), 32'd12);
    chk("m done@14", 32'(e_done[14]), 32'd1);
    sc_err_en = 1'b0;
    do_reset();

    // 4: reboot both cores with clear
    setup("t4", 1);
    reb[18] = 2'b11;
    run(40);
    chk("m rst@19", 32'(e_rst[19]), 32'h0);
    chk("m rst@20", 32'(e_rst[20]), 32'h1);
    chk("m ch@24", 32'(e_ch[24]), 32'd0);
    chk("m rst@28", 32'(e_rst[28]), 32'h0);
    chk("m rst@29", 32'(e_rst[29]), 32'h2);
    chk("m ch@33", 32'(e_ch[33]), 32'd1);
    chk("m rst@37", 32'(e_rst[37]), 32'h0);
    do_reset();

    // 5: reset during ch1 word 2, then full restart
    setup("t5", 1);
    run(12);
    chk("m cyc@12", 32'(e_cyc[12]), 32'd1);
    chk("m adr@12", 32'(e_adr[12]), 32'd8);
    do_reset();
    setup("t5b", 1);
    run(18);
    do_reset();

    // 6: reboot of core 1 requested during HOLD
    setup("t6", 0);
    for (int i = 2; i <= 8; i++) reb[i] = 2'b10;
    run(16);
    chk("m rst@8", 32'(e_rst[8]), 32'h0);
    chk("m rst@9", 32'(e_rst[9]), 32'h2);
    chk("m rst@12", 32'(e_rst[12]), 32'h2);
    chk("m rst@13", 32'(e_rst[13]), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
